// File: rtl/ula_8bits_cmd_ctrl_if.sv
// Command and result handshake bundle for ula_8bits_cmd_ctrl.
// slave = the controller, master = the command producer / result consumer.
interface ula_8bits_cmd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_s;
  logic       cmd_m;
  logic       cmd_c_in;
  logic       cmd_b_in;
  logic       cmd_use_acc;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_f;
  logic       res_c_out;
  logic       res_b_out;
  logic       res_a_eq_b;
  logic       res_zero;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_c_in, cmd_b_in, cmd_use_acc,
    input  cmd_ready,
    input  res_valid, res_f, res_c_out, res_b_out, res_a_eq_b, res_zero,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_c_in, cmd_b_in, cmd_use_acc,
    output cmd_ready,
    output res_valid, res_f, res_c_out, res_b_out, res_a_eq_b, res_zero,
    input  res_ready
  );
endinterface

// File: rtl/ula_8bits_cmd_ctrl.sv
// Command FIFO, registered ALU operand/control issue, and result capture with
// valid/ready output for the 8-bit 74181-style ALU; optional accumulator as A.
module ula_8bits_cmd_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ula_8bits_cmd_ctrl_if.slave         bus,
  output logic [7:0]                  alu_a,
  output logic [7:0]                  alu_b,
  output logic [3:0]                  alu_s,
  output logic                        alu_m,
  output logic                        alu_c_in,
  output logic                        alu_b_in,
  input  logic [7:0]                  alu_f,
  input  logic                        alu_c_out,
  input  logic                        alu_b_out,
  input  logic                        alu_a_eq_b,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic       b_in;
    logic       use_acc;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t       state_q, state_d;
  cmd_t         mem_q [FIFO_DEPTH];
  cmd_t         mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [7:0]   alu_a_q, alu_a_d;
  logic [7:0]   alu_b_q, alu_b_d;
  logic [3:0]   alu_s_q, alu_s_d;
  logic         alu_m_q, alu_m_d;
  logic         alu_c_in_q, alu_c_in_d;
  logic         alu_b_in_q, alu_b_in_d;

  logic [7:0]   acc_q, acc_d;
  logic         res_valid_q, res_valid_d;
  logic [7:0]   res_f_q, res_f_d;
  logic         res_c_out_q, res_c_out_d;
  logic         res_b_out_q, res_b_out_d;
  logic         res_a_eq_b_q, res_a_eq_b_d;
  logic         res_zero_q, res_zero_d;

  logic         cmd_ready;
  logic         push;
  logic         pop;
  logic         capture;
  logic         fifo_empty;
  cmd_t         wr_entry;
  cmd_t         head;

  assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q];

  assign wr_entry.a       = bus.cmd_a;
  assign wr_entry.b       = bus.cmd_b;
  assign wr_entry.s       = bus.cmd_s;
  assign wr_entry.m       = bus.cmd_m;
  assign wr_entry.c_in    = bus.cmd_c_in;
  assign wr_entry.b_in    = bus.cmd_b_in;
  assign wr_entry.use_acc = bus.cmd_use_acc;

  // Pops only read stored entries, so a command always sits in the FIFO for a cycle.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    res_valid_d = res_valid_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture     = 1'b1;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand A is resolved at pop time, so it sees the most recently captured result.
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    alu_m_d    = alu_m_q;
    alu_c_in_d = alu_c_in_q;
    alu_b_in_d = alu_b_in_q;
    if (pop) begin
      alu_a_d    = head.use_acc ? acc_q : head.a;
      alu_b_d    = head.b;
      alu_s_d    = head.s;
      alu_m_d    = head.m;
      alu_c_in_d = head.c_in;
      alu_b_in_d = head.b_in;
    end
  end

  always_comb begin
    acc_d        = acc_q;
    res_f_d      = res_f_q;
    res_c_out_d  = res_c_out_q;
    res_b_out_d  = res_b_out_q;
    res_a_eq_b_d = res_a_eq_b_q;
    res_zero_d   = res_zero_q;
    if (capture) begin
      acc_d        = alu_f;
      res_f_d      = alu_f;
      res_c_out_d  = alu_c_out;
      res_b_out_d  = alu_b_out;
      res_a_eq_b_d = alu_a_eq_b;
      res_zero_d   = (alu_f == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_s_q      <= '0;
      alu_m_q      <= 1'b0;
      alu_c_in_q   <= 1'b0;
      alu_b_in_q   <= 1'b0;
      acc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_f_q      <= '0;
      res_c_out_q  <= 1'b0;
      res_b_out_q  <= 1'b0;
      res_a_eq_b_q <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_s_q      <= alu_s_d;
      alu_m_q      <= alu_m_d;
      alu_c_in_q   <= alu_c_in_d;
      alu_b_in_q   <= alu_b_in_d;
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_f_q      <= res_f_d;
      res_c_out_q  <= res_c_out_d;
      res_b_out_q  <= res_b_out_d;
      res_a_eq_b_q <= res_a_eq_b_d;
      res_zero_q   <= res_zero_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_f      = res_f_q;
  assign bus.res_c_out  = res_c_out_q;
  assign bus.res_b_out  = res_b_out_q;
  assign bus.res_a_eq_b = res_a_eq_b_q;
  assign bus.res_zero   = res_zero_q;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s      = alu_s_q;
  assign alu_m      = alu_m_q;
  assign alu_c_in   = alu_c_in_q;
  assign alu_b_in   = alu_b_in_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ula_8bits_cmd_ctrl.sv
// Scoreboard bench for ula_8bits_cmd_ctrl with a behavioural ALU stub on alu_*.
module tb_ula_8bits_cmd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_8bits_cmd_ctrl_if bus();

  logic [7:0] alu_a, alu_b, alu_f;
  logic [3:0] alu_s;
  logic       alu_m, alu_c_in, alu_b_in;
  logic       alu_c_out, alu_b_out, alu_a_eq_b;
  logic [2:0] fifo_count;

  ula_8bits_cmd_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_c_in   (alu_c_in),
    .alu_b_in   (alu_b_in),
    .alu_f      (alu_f),
    .alu_c_out  (alu_c_out),
    .alu_b_out  (alu_b_out),
    .alu_a_eq_b (alu_a_eq_b),
    .fifo_count (fifo_count)
  );

  // ALU stub: logic ops per 74181 active-high table, add/sub for two arithmetic codes.
  // Flags: c_out = carry of a+b+c_in, b_out = a<b, a_eq_b = a==b.
  logic [8:0] stub_sum;
  always_comb begin
    stub_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
    alu_c_out  = stub_sum[8];
    alu_b_out  = (alu_a < alu_b);
    alu_a_eq_b = (alu_a == alu_b);
    alu_f      = alu_a;
    if (alu_m) begin
      case (alu_s)
        4'b0000: alu_f = ~alu_a;
        4'b0001: alu_f = ~(alu_a | alu_b);
        4'b0010: alu_f = ~alu_a & alu_b;
        4'b0011: alu_f = 8'h00;
        4'b0100: alu_f = ~(alu_a & alu_b);
        4'b0101: alu_f = ~alu_b;
        4'b0110: alu_f = alu_a ^ alu_b;
        4'b0111: alu_f = alu_a & ~alu_b;
        4'b1000: alu_f = ~alu_a | alu_b;
        4'b1001: alu_f = ~(alu_a ^ alu_b);
        4'b1010: alu_f = alu_b;
        4'b1011: alu_f = alu_a & alu_b;
        4'b1100: alu_f = 8'hFF;
        4'b1101: alu_f = alu_a | ~alu_b;
        4'b1110: alu_f = alu_a | alu_b;
        default: alu_f = alu_a;
      endcase
    end else begin
      case (alu_s)
        4'b1001: alu_f = stub_sum[7:0];
        4'b0110: alu_f = alu_a - alu_b - 8'd1 + {7'b0, alu_c_in};
        default: alu_f = alu_a;
      endcase
    end
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       ci;
    logic       bi;
    logic [7:0] f;
    logic       c;
    logic       bo;
    logic       eq;
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_f %h expected no result", bus.res_f);
      end else begin
        mon_e = q.pop_front();
        check("res_fields",
              32'({bus.res_f, bus.res_c_out, bus.res_b_out, bus.res_a_eq_b, bus.res_zero}),
              32'({mon_e.f, mon_e.c, mon_e.bo, mon_e.eq, mon_e.z}));
        check("alu_regs",
              32'({alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_b_in}),
              32'({mon_e.a, mon_e.b, mon_e.s, mon_e.m, mon_e.ci, mon_e.bi}));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      input logic m, input logic ci, input logic bi, input logic ua,
                      input logic [7:0] ea, input logic [7:0] f,
                      input logic c, input logic bo, input logic eq, input logic z);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_wait: got 0 expected 1 within 100 cycles");
      return;
    end
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_s       = s;
    bus.cmd_m       = m;
    bus.cmd_c_in    = ci;
    bus.cmd_b_in    = bi;
    bus.cmd_use_acc = ua;
    bus.cmd_valid   = 1'b1;
    e = '{a: ea, b: b, s: s, m: m, ci: ci, bi: bi, f: f, c: c, bo: bo, eq: eq, z: z};
    q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_s       = '0;
    bus.cmd_m       = 1'b0;
    bus.cmd_c_in    = 1'b0;
    bus.cmd_b_in    = 1'b0;
    bus.cmd_use_acc = 1'b0;
    bus.res_ready   = 1'b1;

    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_b_in}), 32'd0);
    check("rst_res", 32'({bus.res_f, bus.res_c_out, bus.res_b_out, bus.res_a_eq_b, bus.res_zero}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single XOR with latency checks
    send(8'h5A, 8'h0F, 4'b0110, 1, 0, 0, 0, 8'h5A, 8'h55, 0, 0, 0, 0);
    check("t1_count_after_push", 32'(fifo_count), 32'd1);
    check("t1_no_bypass_alu_a", 32'(alu_a), 32'h00);
    @(posedge clk); #1;
    check("t1_alu_a_loaded", 32'(alu_a), 32'h5A);
    check("t1_valid_not_yet", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_high", 32'(bus.res_valid), 32'd1);
    wait_drain();

    // Accumulator chain: A = previous result 55
    send(8'h99, 8'hF0, 4'b1110, 1, 0, 1, 1, 8'h55, 8'hF5, 1, 1, 0, 0);
    wait_drain();
    // Zero flag from logic XOR
    send(8'h3C, 8'h3C, 4'b0110, 1, 0, 0, 0, 8'h3C, 8'h00, 0, 0, 1, 1);
    // Arithmetic add with carry-in, and subtract to zero
    send(8'hC8, 8'h64, 4'b1001, 0, 1, 0, 0, 8'hC8, 8'h2D, 1, 0, 0, 0);
    send(8'h10, 8'h10, 4'b0110, 0, 1, 0, 0, 8'h10, 8'h00, 0, 0, 1, 1);
    wait_drain();

    // Backpressure and full
    bus.res_ready = 1'b0;
    send(8'hFF, 8'h02, 4'b1001, 0, 0, 0, 0, 8'hFF, 8'h01, 1, 0, 0, 0);
    send(8'h01, 8'h02, 4'b1001, 0, 0, 0, 0, 8'h01, 8'h03, 0, 1, 0, 0);
    send(8'hEE, 8'h04, 4'b1001, 0, 0, 0, 1, 8'h03, 8'h07, 0, 1, 0, 0);
    send(8'hA5, 8'h5A, 4'b1110, 1, 0, 0, 0, 8'hA5, 8'hFF, 0, 0, 0, 0);
    send(8'hF0, 8'h0F, 4'b0000, 1, 1, 1, 0, 8'hF0, 8'h0F, 1, 0, 0, 0);
    check("t4_count_full", 32'(fifo_count), 32'd4);
    check("t4_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("t4_hold_valid", 32'(bus.res_valid), 32'd1);
    bus.cmd_a     = 8'h77;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("t4_refused_push", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("t4_res_f_stable", 32'(bus.res_f), 32'h01);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_drain_cycles", 32'(n), 32'd9);
    wait_drain();

    // Simultaneous push and pop in HOLD with two queued
    bus.res_ready = 1'b0;
    send(8'h12, 8'h34, 4'b1001, 0, 0, 0, 0, 8'h12, 8'h46, 0, 1, 0, 0);
    send(8'h80, 8'h80, 4'b1001, 0, 0, 0, 0, 8'h80, 8'h00, 1, 0, 1, 1);
    send(8'h0F, 8'hF0, 4'b1010, 1, 0, 0, 0, 8'h0F, 8'hF0, 0, 1, 0, 0);
    check("t5_count_before", 32'(fifo_count), 32'd2);
    check("t5_hold_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    send(8'h33, 8'h11, 4'b0110, 0, 1, 0, 0, 8'h33, 8'h22, 0, 0, 0, 0);
    check("t5_count_same", 32'(fifo_count), 32'd2);
    check("t5_exec_valid_low", 32'(bus.res_valid), 32'd0);
    check("t5_exec_alu_a", 32'(alu_a), 32'h80);
    wait_drain();

    // Reset during EXEC with two queued
    bus.res_ready = 1'b0;
    send(8'h01, 8'h01, 4'b1001, 0, 0, 0, 0, 8'h01, 8'h02, 0, 0, 1, 0);
    send(8'h02, 8'h01, 4'b1001, 0, 0, 0, 0, 8'h02, 8'h03, 0, 0, 0, 0);
    send(8'h03, 8'h01, 4'b1001, 0, 0, 0, 0, 8'h03, 8'h04, 0, 0, 0, 0);
    bus.res_ready = 1'b1;
    send(8'h04, 8'h01, 4'b1001, 0, 0, 0, 0, 8'h04, 8'h05, 0, 0, 0, 0);
    check("t6_pre_count", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    #1;
    q.delete();
    check("t6_rst_valid", 32'(bus.res_valid), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_alu_a", 32'(alu_a), 32'h00);
    check("t6_rst_res_f", 32'(bus.res_f), 32'h00);
    bus.cmd_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("t6_push_ignored", 32'(fifo_count), 32'd0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t6_no_valid_after_release", 32'(bus.res_valid), 32'd0);
    end
    // Accumulator cleared by reset: 00 | 3C
    send(8'h77, 8'h3C, 4'b1110, 1, 0, 0, 1, 8'h00, 8'h3C, 0, 1, 0, 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_8bits_cmd_ctrl.md
Name: ula_8bits_cmd_ctrl

Overview:
Command front-end and result capture stage wrapped around the 8-bit 74181-style ALU (ula_8bits). It buffers incoming operation commands in a small FIFO and issues them one at a time into registered ALU operand and control lines. One cycle later it captures the ALU outputs into a result register and presents them through a valid/ready handshake. It also provides an accumulator mode, in which the previous result replaces operand A.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command FIFO can accept.
cmd_a, cmd_b  in  8 each  operands.
cmd_s  in  4  operation select.
cmd_m  in  1  0 = arithmetic, 1 = logic.
cmd_c_in, cmd_b_in  in  1 each  carry/borrow in.
cmd_use_acc  in  1  1 = use accumulator as A instead of cmd_a.
alu_a, alu_b  out  8 each  registered, to ALU a/b.
alu_s  out  4  registered, to ALU s.
alu_m, alu_c_in, alu_b_in  out  1 each  registered, to ALU.
alu_f  in  8  ALU result.
alu_c_out, alu_b_out, alu_a_eq_b  in  1 each  ALU flags.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_f  out  8  captured result.
res_c_out, res_b_out, res_a_eq_b  out  1 each  captured flags.
res_zero  out  1  captured (alu_f == 8'h00).
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset: asynchronous on rst_n low; all state is cleared immediately.
  - FIFO is empty and fifo_count = 0.
  - FSM is in IDLE.
  - All alu_* outputs, res_* outputs and res_valid are 0.
  - Accumulator is 8'h00.
- cmd_ready is combinational: (fifo_count != FIFO_DEPTH).
  - It reads 1 during reset, but pushes are ignored while rst_n is low.
- Push occurs on cmd_valid && cmd_ready at a clock edge; the entry stores all cmd_* fields.
- Simultaneous push and pop: both take effect and fifo_count is unchanged.
- No bypass: a command always spends at least one cycle in the FIFO.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head, load the alu_* registers and go to EXEC.
  - EXEC: exactly one cycle. The ALU settles combinationally. At the edge:
    - res_f, res_c_out, res_b_out, res_a_eq_b and res_zero are captured from the alu_* inputs.
    - Accumulator is loaded with alu_f.
    - res_valid is set to 1 and the FSM goes to HOLD.
  - HOLD: res_* and res_valid are held stable while res_ready = 0. On res_valid && res_ready:
    - If FIFO is non-empty, pop and load the alu_* registers in the same edge, clear res_valid and go to EXEC.
    - Otherwise clear res_valid and go to IDLE.
- Operand A selection at pop: alu_a = cmd_use_acc ? accumulator : cmd_a.
  - The accumulator always holds the result of the most recent EXEC, so chained commands see the previous result.
  - The accumulator updates even if that result has not yet been accepted.
- alu_* registers hold their last values in HOLD and IDLE; they change only on a pop.
- Latency: with an empty FIFO and IDLE, a command pushed at edge E0 is popped at E1 and captured at E2.
  - res_valid is first observed high after E2.
  - Sustained throughput is one result per 2 cycles with res_ready held at 1.
- No arithmetic is performed in this block. Flags are passed through unmodified; res_zero is the only derived value.
- Reset asserted mid-operation, in any state: any in-flight command and the pending result are discarded. No res_valid pulse follows reset release.

Test Plan:
1. Single XOR: push a=8'h5A, b=8'h0F, s=4'b0110, m=1, res_ready=1. Expect alu_a=8'h5A two edges after push; res_valid high after the third edge; res_f=8'h55, res_zero=0.
2. Zero flag: push a=8'h3C, b=8'h3C, s=4'b0110, m=1. Expect res_f=8'h00 and res_zero=1.
3. Accumulator chain: after test 1, push b=8'hF0, s=4'b1110, m=1, cmd_use_acc=1. Expect alu_a=8'h55 and res_f=8'hF5.
4. Backpressure and full: hold res_ready=0 and push 5 commands with FIFO_DEPTH=4.
   - First command goes to EXEC and HOLD.
   - cmd_ready drops after fifo_count reaches 4; the 6th push is refused.
   - res_f stays stable throughout.
   - Releasing res_ready drains the FIFO in order, one result every 2 cycles.
5. Simultaneous push and pop: with the FIFO at count 2 in HOLD, assert cmd_valid and res_ready in the same cycle. Expect fifo_count to stay 2 and the FSM to go to EXEC.
6. Reset mid-flight: assert rst_n=0 during EXEC with 2 entries queued. Expect res_valid=0, fifo_count=0, alu_a=0 and accumulator 0 immediately; no result appears after release.
